audio_mix_sched: RTL
====================

Name: audio_mix_sched

Overview:
Frame scheduler for the audio output path. Each frame it polls up to NUM_VOICES stereo voice generators in round-robin index order over a req/ack handshake. It sums the enabled voices per channel with signed saturation and writes one 64-bit frame into the audio_out sample FIFO whenever that FIFO is not full. It is the only writer of the audio_out FIFO, so FIFO backpressure paces the whole synthesis chain.

Parameters:
NUM_VOICES, 4, number of voice requesters (1..16)
SAMPLE_W, 32, bits per channel; frame = {left, right}, 2*SAMPLE_W bits
TIMEOUT, 255, max clk cycles to wait for a voice ack before skipping the voice

Ports:
clk  in  1  global clock
aclr  in  1  synchronous active-high reset
voice_en  in  NUM_VOICES  per-voice enable, latched at frame start
voice_req  out  NUM_VOICES  one-hot request to the voice being polled
voice_ack  in  NUM_VOICES  voice data valid; sampled only at the polled index
voice_data  in  NUM_VOICES*2*SAMPLE_W  voice i at [i*64 +: 64]; left in the upper half
mute  in  1  forces the output frame to zero; handshakes still run
wrfull  in  1  audio_out FIFO full
wrreq  out  1  one-cycle FIFO write strobe
sample  out  2*SAMPLE_W  frame to the FIFO; valid while wrreq=1
frame_cnt  out  16  frames written, wraps at 0xFFFF->0
voice_err  out  NUM_VOICES  sticky timeout flag per voice
err_clr  in  1  clears voice_err (reset-equivalent for those bits only)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (aclr=1 at a clk edge) forces the following, from any state: state=IDLE, voice_req=0, wrreq=0, sample=0, frame_cnt=0, voice_err=0, busy=0, accumulators=0. Any in-flight handshake is abandoned without a wrreq.
- Accumulators: one per channel, signed, SAMPLE_W+clog2(NUM_VOICES) bits. Inputs are sign-extended.
- States:
  - IDLE: if wrfull=0, latch voice_en into en_q, clear both accumulators, idx=0, go to SCAN. Otherwise stay in IDLE.
  - SCAN: if en_q[idx]=1, go to REQ with timer=0. Otherwise, if idx is the last voice go to SAT, else idx++. Each skipped voice costs one cycle.
  - REQ: voice_req[idx]=1, held until exit.
    - voice_ack[idx]=1: add voice_data[idx] into the accumulators, drop req on the next cycle, then advance (idx++ and go to SCAN, or go to SAT after the last voice).
    - timer==TIMEOUT without ack: set voice_err[idx], add nothing, advance the same way.
    - Acks on other indices are ignored.
  - SAT: clamp each channel to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] (for SAMPLE_W=32: 0x80000000..0x7FFFFFFF). If mute=1, the frame is 0. Register the frame into sample, then go to WR.
  - WR: if wrfull=0, assert wrreq for exactly one cycle, increment frame_cnt, go to IDLE. If wrfull=1, hold sample and wait; never write into a full FIFO.
- Latency: when every voice acks on its first req cycle, a frame with N enabled voices takes 1 (IDLE) + N*(1 SCAN + 1 REQ) + 1 (SAT) + 1 (WR) cycles, plus one cycle per disabled voice.
- No voices enabled: SCAN runs through all indices and a zero frame is written. The FIFO is still fed.
- voice_en changes mid-frame: no effect until the next IDLE->SCAN transition.
- err_clr and a timeout in the same cycle: the set wins.
- voice_data is only sampled in the ack cycle. A voice may hold ack high across frames; each REQ entry consumes it once.
- frame_cnt wraps silently from 0xFFFF to 0.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W and the frame-width constant
  - state enum {IDLE, SCAN, REQ, SAT, WR}
  - the signed saturation function (also reused by future mixers)
- One natural sub-module, audio_sat_acc: a per-channel accumulator with clear, add enable and saturating output, instantiated twice (left, right). The FSM stays in the top level.

Test Plan:
- 4 voices enabled, voice i returns L=R=i*0x1000 on an immediate ack, wrfull=0 -> wrreq pulses with sample = {0x00006000, 0x00006000}, frame_cnt=1, 11 cycles from IDLE exit to wrreq.
- Two voices at L=0x7FFFFFFF plus one at L=0x00000001, R at -0x80000000 ×3 -> sample = {0x7FFFFFFF, 0x80000000}.
- Voice 2 never acks, TIMEOUT=255 -> voice_req[2] high for 256 cycles, voice_err=4'b0100, frame written without voice 2's contribution; err_clr pulse -> voice_err=0.
- wrfull=1 held -> stays in IDLE, no voice_req. Force wrfull=1 during WR for 5 cycles -> wrreq stays 0, then one pulse when wrfull falls, sample stable throughout.
- voice_en=0 with mute=1 and all voices active -> frames are all-zero and wrreq continues. Toggle voice_en mid-frame -> sum reflects only the mask latched at frame start.
- aclr asserted while voice_req[1]=1 -> next cycle voice_req=0, wrreq=0, frame_cnt=0, busy=0. After release, normal frames resume.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and helpers: sample/frame widths, scheduler states and
// the signed saturation used by the mixers.
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int FRAME_W  = 2 * SAMPLE_W;
  // Widest accumulator any mixer may hand to sat_sample (16 voices).
  localparam int SAT_IN_W = SAMPLE_W + 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    REQ  = 3'd2,
    SAT  = 3'd3,
    WR   = 3'd4
  } state_t;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX =
    {{(SAT_IN_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN =
    {{(SAT_IN_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  function automatic logic [SAMPLE_W-1:0] sat_sample(
    input logic signed [SAT_IN_W-1:0] v
  );
    logic [SAMPLE_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[SAMPLE_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_mix_sched_if.sv
// Voice polling handshake and audio_out FIFO write port of the frame scheduler.
interface audio_mix_sched_if
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4
);

  logic [NUM_VOICES-1:0]         voice_req;
  logic [NUM_VOICES-1:0]         voice_ack;
  logic [NUM_VOICES*FRAME_W-1:0] voice_data;
  logic                          wrfull;
  logic                          wrreq;
  logic [FRAME_W-1:0]            sample;

  modport master (
    output voice_req, wrreq, sample,
    input  voice_ack, voice_data, wrfull
  );

  modport slave (
    input  voice_req, wrreq, sample,
    output voice_ack, voice_data, wrfull
  );

endinterface

// File: rtl/audio_sat_acc.sv
// One mixing channel: signed accumulator with clear and add enable, and a
// saturated SAMPLE_W-bit view of the running sum.
module audio_sat_acc
  import audio_pkg::*;
#(
  parameter int ACC_W = SAMPLE_W + 2
)(
  input  logic                clk,
  input  logic                aclr,
  input  logic                clr,
  input  logic                add_en,
  input  logic [SAMPLE_W-1:0] din,
  output logic [SAMPLE_W-1:0] sat_out
);

  logic signed [ACC_W-1:0] acc_r;

  // Running sum; sign-extends each sample before adding.
  always_ff @(posedge clk) begin
    if (aclr) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (add_en) begin
      acc_r <= acc_r + ACC_W'($signed(din));
    end else begin
      acc_r <= acc_r;
    end
  end

  assign sat_out = sat_sample(SAT_IN_W'(acc_r));

endmodule

// File: rtl/audio_mix_sched.sv
// Frame scheduler: polls enabled voices round-robin, mixes them with signed
// saturation and writes one stereo frame per pass into the audio_out FIFO.
module audio_mix_sched
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int TIMEOUT    = 255
)(
  input  logic                  clk,
  input  logic                  aclr,
  audio_mix_sched_if.master     bus,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic                  mute,
  input  logic                  err_clr,
  output logic [15:0]           frame_cnt,
  output logic [NUM_VOICES-1:0] voice_err,
  output logic                  busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  state_t                state_r, state_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [TMR_W-1:0]      timer_r, timer_s;
  logic [NUM_VOICES-1:0] en_q_r, en_q_s;
  logic [NUM_VOICES-1:0] voice_req_r, req_s;
  logic [NUM_VOICES-1:0] voice_err_r, err_set_s;
  logic                  wrreq_r;
  logic [FRAME_W-1:0]    sample_r;
  logic [15:0]           frame_cnt_r;
  logic                  busy_r;

  logic                  acc_clr_s;
  logic                  acc_add_s;
  logic                  wr_fire_s;
  logic                  timeout_s;
  logic                  ack_sel_s;
  logic [FRAME_W-1:0]    data_sel_s;
  logic [SAMPLE_W-1:0]   sat_l_s;
  logic [SAMPLE_W-1:0]   sat_r_s;

  // Only the polled voice's ack and data are ever looked at.
  assign ack_sel_s  = bus.voice_ack[idx_r];
  assign data_sel_s = bus.voice_data[int'(idx_r) * FRAME_W +: FRAME_W];

  audio_sat_acc #(.ACC_W(ACC_W)) u_acc_left (
    .clk     (clk),
    .aclr    (aclr),
    .clr     (acc_clr_s),
    .add_en  (acc_add_s),
    .din     (data_sel_s[FRAME_W-1:SAMPLE_W]),
    .sat_out (sat_l_s)
  );

  audio_sat_acc #(.ACC_W(ACC_W)) u_acc_right (
    .clk     (clk),
    .aclr    (aclr),
    .clr     (acc_clr_s),
    .add_en  (acc_add_s),
    .din     (data_sel_s[SAMPLE_W-1:0]),
    .sat_out (sat_r_s)
  );

  // Next-state and per-cycle controls of the polling FSM.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    timer_s   = timer_r;
    en_q_s    = en_q_r;
    acc_clr_s = 1'b0;
    acc_add_s = 1'b0;
    wr_fire_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.wrfull) begin
          en_q_s    = voice_en;
          acc_clr_s = 1'b1;
          idx_s     = '0;
          state_s   = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (en_q_r[idx_r]) begin
          timer_s = '0;
          state_s = REQ;
        end else if (idx_r == LAST_IDX) begin
          state_s = SAT;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      REQ: begin
        if (ack_sel_s || (timer_r == TMR_MAX)) begin
          acc_add_s = ack_sel_s;
          timeout_s = !ack_sel_s;
          if (idx_r == LAST_IDX) begin
            state_s = SAT;
          end else begin
            idx_s   = idx_r + IDX_W'(1);
            state_s = SCAN;
          end
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      SAT: begin
        state_s = WR;
      end
      WR: begin
        if (!bus.wrfull) begin
          wr_fire_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = WR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One-hot decode of next request and of the voice that just timed out.
  always_comb begin
    req_s     = '0;
    err_set_s = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      req_s[i]     = (state_s == REQ) && (idx_s == IDX_W'(i));
      err_set_s[i] = timeout_s && (idx_r == IDX_W'(i));
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      timer_r     <= '0;
      en_q_r      <= '0;
      voice_req_r <= '0;
      voice_err_r <= '0;
      wrreq_r     <= 1'b0;
      sample_r    <= '0;
      frame_cnt_r <= 16'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      timer_r     <= timer_s;
      en_q_r      <= en_q_s;
      voice_req_r <= req_s;
      // A timeout in the same cycle as err_clr still leaves its flag set.
      voice_err_r <= (err_clr ? '0 : voice_err_r) | err_set_s;
      wrreq_r     <= wr_fire_s;
      frame_cnt_r <= frame_cnt_r + 16'(wr_fire_s);
      busy_r      <= (state_s != IDLE);
      if (state_r == SAT) begin
        sample_r <= mute ? '0 : {sat_l_s, sat_r_s};
      end else begin
        sample_r <= sample_r;
      end
    end
  end

  assign bus.voice_req = voice_req_r;
  assign bus.wrreq     = wrreq_r;
  assign bus.sample    = sample_r;
  assign frame_cnt     = frame_cnt_r;
  assign voice_err     = voice_err_r;
  assign busy          = busy_r;

endmodule
